// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like bus bundle: request fields flow master->slave, responses flow back.
interface sram_bus_arbiter_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wen;
   logic [31:0] rdata;
   logic        addr_ok;
   logic        data_ok;

   modport master (output req, wr, size, addr, wdata, wen,
                   input  rdata, addr_ok, data_ok);
   modport slave  (input  req, wr, size, addr, wdata, wen,
                   output rdata, addr_ok, data_ok);
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-master (inst/data cache) to one-slave SRAM-bus arbiter, one outstanding
// transaction, grant held from address phase to data_ok, with data-phase watchdog.
module sram_bus_arbiter #(
   parameter bit RR_EN     = 1'b1,
   parameter int TIMEOUT_W = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   sram_bus_arbiter_if.slave    inst,
   sram_bus_arbiter_if.slave    data,
   sram_bus_arbiter_if.master   mem,
   output logic                 owner,
   output logic                 busy,
   output logic                 err
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   localparam logic [TIMEOUT_W-1:0] WDOG_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

   state_t               state;
   logic                 last;
   logic [TIMEOUT_W-1:0] wdog;

   logic in_addr, in_data, owner_req, timeout, done, grant_data;

   always_comb begin
      in_addr    = (state == ADDR);
      in_data    = (state == DATA);
      owner_req  = owner ? data.req : inst.req;
      timeout    = in_data && (wdog == '1);
      done       = in_data && (mem.data_ok || timeout);
      // last==0 means inst was served last, so data wins a tie
      grant_data = RR_EN ? (data.req && (!inst.req || !last)) : data.req;

      mem.req   = in_addr;
      mem.wr    = in_addr && (owner ? data.wr : inst.wr);
      mem.size  = in_addr ? (owner ? data.size  : inst.size)  : 2'd0;
      mem.addr  = in_addr ? (owner ? data.addr  : inst.addr)  : 32'd0;
      mem.wdata = in_addr ? (owner ? data.wdata : inst.wdata) : 32'd0;
      mem.wen   = in_addr ? (owner ? data.wen   : inst.wen)   : 4'd0;

      inst.addr_ok = in_addr && !owner && mem.addr_ok;
      data.addr_ok = in_addr &&  owner && mem.addr_ok;
      inst.data_ok = done && !owner;
      data.data_ok = done &&  owner;
      inst.rdata   = in_data ? mem.rdata : 32'd0;
      data.rdata   = in_data ? mem.rdata : 32'd0;

      busy = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= 1'b0;
         wdog  <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mem.data_ok) err <= 1'b1;
               if (inst.req || data.req) begin
                  owner <= grant_data;
                  state <= ADDR;
               end
            end
            ADDR: begin
               if (mem.data_ok) err <= 1'b1;
               if (!owner_req) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end else if (mem.addr_ok) begin
                  wdog  <= '0;
                  state <= DATA;
               end
            end
            DATA: begin
               if (done) begin
                  // a watchdog release is an error unless the slave answered the same cycle
                  if (timeout && !mem.data_ok) err <= 1'b1;
                  last  <= owner;
                  state <= IDLE;
               end else begin
                  wdog <= wdog + WDOG_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance share stimulus.
module tb_sram_bus_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata, mem_rdata;
   logic [3:0]  inst_wen, data_wen;
   logic        mem_addr_ok, mem_data_ok;
   logic        owner_rr, busy_rr, err_rr, owner_fp, busy_fp, err_fp;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sram_bus_arbiter_if ii_rr ();
   sram_bus_arbiter_if di_rr ();
   sram_bus_arbiter_if mi_rr ();
   sram_bus_arbiter_if ii_fp ();
   sram_bus_arbiter_if di_fp ();
   sram_bus_arbiter_if mi_fp ();

   assign ii_rr.req = inst_req;  assign ii_rr.wr = inst_wr;  assign ii_rr.size = inst_size;
   assign ii_rr.addr = inst_addr; assign ii_rr.wdata = inst_wdata; assign ii_rr.wen = inst_wen;
   assign di_rr.req = data_req;  assign di_rr.wr = data_wr;  assign di_rr.size = data_size;
   assign di_rr.addr = data_addr; assign di_rr.wdata = data_wdata; assign di_rr.wen = data_wen;
   assign mi_rr.rdata = mem_rdata; assign mi_rr.addr_ok = mem_addr_ok; assign mi_rr.data_ok = mem_data_ok;
   assign ii_fp.req = inst_req;  assign ii_fp.wr = inst_wr;  assign ii_fp.size = inst_size;
   assign ii_fp.addr = inst_addr; assign ii_fp.wdata = inst_wdata; assign ii_fp.wen = inst_wen;
   assign di_fp.req = data_req;  assign di_fp.wr = data_wr;  assign di_fp.size = data_size;
   assign di_fp.addr = data_addr; assign di_fp.wdata = data_wdata; assign di_fp.wen = data_wen;
   assign mi_fp.rdata = mem_rdata; assign mi_fp.addr_ok = mem_addr_ok; assign mi_fp.data_ok = mem_data_ok;

   sram_bus_arbiter #(.RR_EN(1'b1), .TIMEOUT_W(3)) dut_rr (
      .clk(clk), .resetn(resetn), .inst(ii_rr), .data(di_rr), .mem(mi_rr),
      .owner(owner_rr), .busy(busy_rr), .err(err_rr));

   sram_bus_arbiter #(.RR_EN(1'b0), .TIMEOUT_W(3)) dut_fp (
      .clk(clk), .resetn(resetn), .inst(ii_fp), .data(di_fp), .mem(mi_fp),
      .owner(owner_fp), .busy(busy_fp), .err(err_fp));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic idle_inputs;
      inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0; inst_wen = 0;
      data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0; data_wen = 0;
      mem_rdata = 0; mem_addr_ok = 0; mem_data_ok = 0;
   endtask

   task automatic do_reset;
      resetn = 1'b0;
      idle_inputs();
      tick();
      resetn = 1'b1;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      idle_inputs();
      inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
      tick(); tick();
      settle();
      n_checks++;
      if ({busy_rr, owner_rr, err_rr, mi_rr.req, di_rr.data_ok, ii_rr.data_ok} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_rr: got %b expected 000000", {busy_rr, owner_rr, err_rr, mi_rr.req, di_rr.data_ok, ii_rr.data_ok});
      end
      n_checks++;
      if ({busy_fp, owner_fp, err_fp, mi_fp.req} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_fp: got %b expected 0000", {busy_fp, owner_fp, err_fp, mi_fp.req});
      end
      idle_inputs();
      resetn = 1'b1;
   endtask

   task automatic test_single_read;
      logic [5:0] exp_tab [6] = '{6'b000000, 6'b100001, 6'b110001, 6'b000001, 6'b001001, 6'b000000};
      logic [5:0] got;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         if (c > 0) tick();
         inst_req    = (c < 3);
         inst_addr   = 32'hBFC0_0000;
         mem_addr_ok = (c == 2);
         mem_data_ok = (c == 4);
         mem_rdata   = (c == 4) ? 32'h3C1D_0000 : 32'h0;
         settle();
         got = {mi_rr.req, ii_rr.addr_ok, ii_rr.data_ok, di_rr.addr_ok, di_rr.data_ok, busy_rr};
         n_checks++;
         if (got !== exp_tab[c]) begin
            n_fail++;
            $display("FAIL single_read c%0d {mreq,iaok,idok,daok,ddok,busy}: got %b expected %b", c, got, exp_tab[c]);
         end
         if (c == 1) begin
            n_checks++;
            if (mi_rr.addr !== 32'hBFC0_0000) begin
               n_fail++;
               $display("FAIL single_read mem_addr: got %h expected bfc00000", mi_rr.addr);
            end
         end
         if (c == 4) begin
            n_checks++;
            if (ii_rr.rdata !== 32'h3C1D_0000) begin
               n_fail++;
               $display("FAIL single_read inst_rdata: got %h expected 3c1d0000", ii_rr.rdata);
            end
         end
      end
      n_checks++;
      if (err_rr !== 1'b0) begin
         n_fail++;
         $display("FAIL single_read err: got %b expected 0", err_rr);
      end
   endtask

   // Both masters hold req; slave answers addr_ok at once and data_ok on the first DATA cycle.
   task automatic test_round_robin;
      int ph, k;
      logic own;
      logic [7:0]  exp_v, got_v;
      logic [67:0] exp_f, got_f;
      do_reset();
      inst_req = 1; inst_addr = 32'h0000_1000; inst_wr = 0;
      data_req = 1; data_addr = 32'h0000_2000; data_wr = 1;
      data_wdata = 32'hDEAD_BEEF; data_wen = 4'hF;
      mem_addr_ok = 1;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) tick();
         ph  = (c > 0) ? (c - 1) % 3 : 2;
         k   = (c > 0) ? (c - 1) / 3 : 0;
         own = (c > 0) ? ((k % 2) == 0) : 1'b0;
         mem_data_ok = (c > 0) && (ph == 1);
         settle();
         case (ph)
            0: exp_v = {1'b1, 1'b1, own, own, !own, 1'b0, own, 1'b0};
            1: exp_v = {1'b1, 1'b0, 1'b0, own, 1'b0, !own, 1'b0, own};
            default: exp_v = {1'b0, 1'b0, 1'b0, own, 4'b0};
         endcase
         if (ph == 0) exp_f = own ? {32'h0000_2000, 32'hDEAD_BEEF, 4'hF} : {32'h0000_1000, 32'h0, 4'h0};
         else         exp_f = '0;
         got_v = {busy_rr, mi_rr.req, mi_rr.wr, owner_rr, ii_rr.addr_ok, ii_rr.data_ok, di_rr.addr_ok, di_rr.data_ok};
         got_f = {mi_rr.addr, mi_rr.wdata, mi_rr.wen};
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL round_robin c%0d {busy,mreq,mwr,own,iaok,idok,daok,ddok}: got %b expected %b", c, got_v, exp_v);
         end
         n_checks++;
         if (got_f !== exp_f) begin
            n_fail++;
            $display("FAIL round_robin c%0d {addr,wdata,wen}: got %h expected %h", c, got_f, exp_f);
         end
      end
   endtask

   task automatic test_fixed_priority;
      int ph;
      int n_done = 0;
      logic [5:0] exp_v, got_v;
      do_reset();
      inst_req = 1; inst_addr = 32'h0000_1000;
      data_req = 1; data_addr = 32'h0000_2000; data_wr = 1;
      mem_addr_ok = 1;
      for (int c = 1; c < 10; c++) begin
         tick();
         ph = (c - 1) % 3;
         mem_data_ok = (ph == 1);
         settle();
         case (ph)
            0: exp_v = 6'b11_1_0_0_0;
            1: exp_v = 6'b10_1_0_0_1;
            default: exp_v = 6'b00_1_0_0_0;
         endcase
         got_v = {busy_fp, mi_fp.req, owner_fp, ii_fp.addr_ok, ii_fp.data_ok, di_fp.data_ok};
         if (di_fp.data_ok === 1'b1) n_done++;
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL fixed_priority c%0d {busy,mreq,own,iaok,idok,ddok}: got %b expected %b", c, got_v, exp_v);
         end
      end
      n_checks++;
      if (n_done != 3) begin
         n_fail++;
         $display("FAIL fixed_priority data_done_count: got %0d expected 3", n_done);
      end
   endtask

   // Data master keeps req high through DATA; slave keeps addr_ok high and delays data_ok.
   task automatic test_hold_req;
      int n_mreq = 0, n_aok = 0, n_dok = 0;
      logic exp_busy;
      do_reset();
      data_req = 1; data_addr = 32'h0000_3000;
      for (int c = 0; c < 9; c++) begin
         if (c > 0) tick();
         data_req    = (c < 8);
         mem_addr_ok = (c >= 1) && (c <= 7);
         mem_data_ok = (c == 7);
         settle();
         exp_busy = (c >= 1) && (c <= 7);
         n_checks++;
         if (busy_rr !== exp_busy) begin
            n_fail++;
            $display("FAIL hold_req c%0d busy: got %b expected %b", c, busy_rr, exp_busy);
         end
         if (mi_rr.req === 1'b1) n_mreq++;
         if (di_rr.addr_ok === 1'b1) n_aok++;
         if (di_rr.data_ok === 1'b1) n_dok++;
      end
      n_checks++;
      if ({n_mreq[3:0], n_aok[3:0], n_dok[3:0]} !== 12'h111) begin
         n_fail++;
         $display("FAIL hold_req counts mreq/aok/dok: got %0d/%0d/%0d expected 1/1/1", n_mreq, n_aok, n_dok);
      end
      n_checks++;
      if (err_rr !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_req err: got %b expected 0", err_rr);
      end
   endtask

   task automatic test_timeout;
      logic [2:0] exp_v, got_v;
      do_reset();
      data_req = 1; data_addr = 32'h0000_4000;
      mem_rdata = 32'hA5A5_A5A5;
      for (int c = 0; c < 11; c++) begin
         if (c > 0) tick();
         data_req    = (c < 10);
         mem_addr_ok = (c == 1);
         settle();
         exp_v = {(c >= 1) && (c <= 9), c == 9, c >= 10};
         got_v = {busy_rr, di_rr.data_ok, err_rr};
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL timeout c%0d {busy,ddok,err}: got %b expected %b", c, got_v, exp_v);
         end
         if (c == 9) begin
            n_checks++;
            if (di_rr.rdata !== 32'hA5A5_A5A5) begin
               n_fail++;
               $display("FAIL timeout data_rdata: got %h expected a5a5a5a5", di_rr.rdata);
            end
         end
      end
      tick(); tick(); tick();
      settle();
      n_checks++;
      if (err_rr !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout err_sticky: got %b expected 1", err_rr);
      end
      do_reset();
      settle();
      n_checks++;
      if (err_rr !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout err_cleared: got %b expected 0", err_rr);
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      data_req = 1; data_addr = 32'h0000_5000;
      tick();
      mem_addr_ok = 1;
      settle();
      n_checks++;
      if (di_rr.addr_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid addr_ok: got %b expected 1", di_rr.addr_ok);
      end
      tick();
      mem_addr_ok = 0; data_req = 0; resetn = 0;
      settle();
      n_checks++;
      if ({busy_rr, owner_rr} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_mid in_data {busy,owner}: got %b expected 11", {busy_rr, owner_rr});
      end
      tick();
      resetn = 1; mem_data_ok = 1;
      settle();
      n_checks++;
      if ({busy_rr, err_rr, owner_rr, di_rr.data_ok, ii_rr.data_ok} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_mid after {busy,err,owner,ddok,idok}: got %b expected 00000",
                  {busy_rr, err_rr, owner_rr, di_rr.data_ok, ii_rr.data_ok});
      end
      tick();
      mem_data_ok = 0;
      settle();
      n_checks++;
      if (err_rr !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid late_data_ok err: got %b expected 1", err_rr);
      end
   endtask

   task automatic test_protocol;
      do_reset();
      inst_req = 1; inst_addr = 32'h0000_6000;
      tick();
      inst_req = 0;
      settle();
      n_checks++;
      if ({busy_rr, mi_rr.req, err_rr} !== 3'b110) begin
         n_fail++;
         $display("FAIL protocol addr {busy,mreq,err}: got %b expected 110", {busy_rr, mi_rr.req, err_rr});
      end
      tick();
      settle();
      n_checks++;
      if ({busy_rr, err_rr} !== 2'b01) begin
         n_fail++;
         $display("FAIL protocol drop {busy,err}: got %b expected 01", {busy_rr, err_rr});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL sim_time_limit: reached %0t without finishing", $time);
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_fixed_priority();
      test_hold_req();
      test_timeout();
      test_reset_mid();
      test_protocol();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
